// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan driver: digit/segment codes,
// conversion FSM encoding and the BCD adjust step used by the shift-add-3 converter.
package seg_pkg;

  localparam int NUM_DIGITS = 6;
  localparam int BCD_W      = 24;
  localparam int BIN_W      = 20;

  // Active-low {dp,g,f,e,d,c,b,a}; dp is left dark in every code.
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_MINUS = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } conv_state_t;

  function automatic logic [7:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Pre-shift correction: any nibble >= 5 gets +3 so the following shift carries correctly.
  function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 20-bit binary to 6-digit BCD converter (shift-add-3) with display shadow registers
// that are only ever written with a complete result.
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int MAX_NUM = 999_999
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      data,
  input  logic [NUM_DIGITS-1:0] point,
  input  logic                  sign,
  output logic                  busy,
  output logic [BCD_W-1:0]      disp_bcd,
  output logic [NUM_DIGITS-1:0] disp_point,
  output logic                  disp_sign
);

  localparam logic [BIN_W-1:0] MAX_BIN  = BIN_W'(MAX_NUM);
  localparam logic [4:0]       LAST_BIT = 5'(BIN_W - 1);

  conv_state_t           state, state_nxt;
  logic [4:0]            shift_cnt;
  logic [BIN_W-1:0]      bin_q;
  logic [BCD_W-1:0]      bcd_q;
  logic [BCD_W-1:0]      bcd_adj;
  logic [NUM_DIGITS-1:0] point_q;
  logic                  sign_q;
  logic [BIN_W-1:0]      data_sat;

  assign data_sat = (data > MAX_BIN) ? MAX_BIN : data;
  assign bcd_adj  = bcd_adjust(bcd_q);

  // NOTE: state and datapath registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block is given a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_LOAD;
      ST_LOAD: begin
        busy      = 1'b1;
        state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        busy = 1'b1;
        if (shift_cnt == LAST_BIT) state_nxt = ST_DONE;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_cnt  <= '0;
      bin_q      <= '0;
      bcd_q      <= '0;
      point_q    <= '0;
      sign_q     <= 1'b0;
      disp_bcd   <= '0;
      disp_point <= '0;
      disp_sign  <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          bin_q     <= data_sat;
          bcd_q     <= '0;
          point_q   <= point;
          sign_q    <= sign;
          shift_cnt <= '0;
        end
        ST_SHIFT: begin
          bcd_q     <= {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
          bin_q     <= {bin_q[BIN_W-2:0], 1'b0};
          shift_cnt <= shift_cnt + 5'd1;
        end
        // All three shadows move together so the scan never mixes old and new values.
        ST_DONE: begin
          disp_bcd   <= bcd_q;
          disp_point <= point_q;
          disp_sign  <= sign_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Six-digit multiplexed common-anode seven-segment driver with sequential BCD conversion.
// Build option SEG_LZ_BLANK_EN: blank leading zeros and float the minus sign next to the top digit.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int SCAN_HZ  = 1_000,
  parameter int MAX_NUM  = 999_999
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BIN_W-1:0]      data,
  input  logic [NUM_DIGITS-1:0] point,
  input  logic                  en,
  input  logic                  sign,
  output logic [NUM_DIGITS-1:0] seg_sel,
  output logic [7:0]            seg_led,
  output logic                  busy
);

  localparam int               DIV      = CLK_FREQ / SCAN_HZ;
  localparam int               DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [2:0]       IDX_LAST = 3'(NUM_DIGITS - 1);

  logic [DIV_W-1:0]      div_cnt;
  logic [2:0]            scan_idx;
  logic [BCD_W-1:0]      disp_bcd;
  logic [NUM_DIGITS-1:0] disp_point;
  logic                  disp_sign;
  logic [3:0]            cur_digit;
  logic                  cur_point;
  logic [7:0]            led_nxt;

  bin2bcd_seq #(
    .MAX_NUM (MAX_NUM)
  ) u_bin2bcd (
    .clk        (clk),
    .rst        (rst),
    .start      (en),
    .data       (data),
    .point      (point),
    .sign       (sign),
    .busy       (busy),
    .disp_bcd   (disp_bcd),
    .disp_point (disp_point),
    .disp_sign  (disp_sign)
  );

  // The scan keeps running while the display is disabled so re-enabling resumes mid-sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt  <= '0;
      scan_idx <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt  <= '0;
      scan_idx <= (scan_idx == IDX_LAST) ? 3'd0 : scan_idx + 3'd1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

`ifdef SEG_LZ_BLANK_EN
  logic [2:0] msd;
`endif

  always_comb begin
    cur_digit = 4'd0;
    cur_point = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scan_idx == 3'(i)) begin
        cur_digit = disp_bcd[4*i +: 4];
        cur_point = disp_point[i];
      end
    end
`ifdef SEG_LZ_BLANK_EN
    // Most significant non-zero digit; stays 0 for value 0 so the units digit always shows.
    msd = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (disp_bcd[4*i +: 4] != 4'd0) msd = 3'(i);
    end
    if (scan_idx <= msd)                          led_nxt = seg_digit(cur_digit);
    else if (disp_sign && scan_idx == msd + 3'd1) led_nxt = SEG_MINUS;
    else                                          led_nxt = SEG_BLANK;
`else
    if (disp_sign && scan_idx == IDX_LAST && cur_digit == 4'd0) led_nxt = SEG_MINUS;
    else                                                        led_nxt = seg_digit(cur_digit);
`endif
    if (cur_point) led_nxt[7] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      seg_sel <= '1;
      seg_led <= SEG_BLANK;
    end else begin
      seg_sel <= ~(6'b1 << scan_idx);
      seg_led <= led_nxt;
    end
  end

endmodule
